// File: rtl/i_fetch_queue_if.sv
// Instruction-fetch front-end bus: redirect input, instruction-memory read port and
// decoder-facing valid/ready output.
//   master : the fetch queue (drives imem_en/imem_addr and the out_* head signals)
//   slave  : the surrounding pipeline / memory / testbench
interface i_fetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 3
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_plus_4;
  logic [CNT_W-1:0]  count;
  logic              align_err;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_en, imem_addr, out_valid, out_instr, out_pc, out_pc_plus_4, count, align_err
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_en, imem_addr, out_valid, out_instr, out_pc, out_pc_plus_4, count, align_err
  );
endinterface

// File: rtl/i_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential reads to a 1-cycle
// synchronous instruction memory and buffers {instr, pc, pc+4} in a DEPTH-entry queue.
// A redirect flushes the queue, kills the in-flight read and restarts fetch at the target.
// Ports:
//   clk  - system clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - i_fetch_queue_if.master: redirect in, imem read port (imem_en/imem_addr are
//          combinational), decoder handshake out_*, occupancy count, align_err pulse
module i_fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  i_fetch_queue_if.master   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic              r_inflight;
  logic              r_align_err;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_mem_instr [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc    [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc4   [DEPTH];

  logic              w_flush;
  logic              w_issue;
  logic              w_pop;
  logic              w_wr;
  logic [CNT_W:0]    w_credit_used;

  // Credit counts both buffered words and the read in flight; a same-cycle pop frees no
  // slot, so a returning word always has room and no full-write case exists.
  assign w_flush       = bus.redirect_valid;
  assign w_credit_used = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_inflight);
  assign w_issue       = !rst && !w_flush && (w_credit_used < (CNT_W+1)'(DEPTH));
  assign w_pop         = (r_count != '0) && bus.out_ready;
  // A response returning in the redirect cycle belongs to the old stream
  assign w_wr          = r_inflight && !w_flush;

  // Fetch PC, in-flight tracking, queue storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_resp_pc   <= '0;
      r_inflight  <= 1'b0;
      r_align_err <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
        r_mem_pc4[i]   <= '0;
      end
    end else begin
      r_align_err <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      r_inflight  <= w_issue;
      if (w_issue) begin
        r_resp_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_flush) begin
        r_fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        r_tail     <= r_head;
        r_count    <= '0;
      end else begin
        if (w_wr) begin
          r_mem_instr[r_tail] <= bus.imem_rdata;
          r_mem_pc[r_tail]    <= r_resp_pc;
          r_mem_pc4[r_tail]   <= r_resp_pc + ADDR_W'(4);
          r_tail              <= r_tail + PTR_W'(1);
        end
        if (w_pop) begin
          r_head <= r_head + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_pop);
      end
    end
  end

  // Head entry is presented directly; when empty it simply holds stale contents
  assign bus.imem_en       = w_issue;
  assign bus.imem_addr     = r_fetch_pc;
  assign bus.out_valid     = (r_count != '0);
  assign bus.out_instr     = r_mem_instr[r_head];
  assign bus.out_pc        = r_mem_pc[r_head];
  assign bus.out_pc_plus_4 = r_mem_pc4[r_head];
  assign bus.count         = r_count;
  assign bus.align_err     = r_align_err;
endmodule

// File: tb/tb_i_fetch_queue.sv
// Bench for i_fetch_queue: a 32-bit DEPTH=4 instance checked every cycle against a queue
// model, plus an 8-bit instance for PC wrap-around and mid-stream reset.
module tb_i_fetch_queue;
  localparam int unsigned AW1   = 32;
  localparam int unsigned AW2   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
  localparam logic [31:0] RPC1  = 32'h100;
  localparam logic [7:0]  RPC2  = 8'hF8;

  logic clk  = 1'b0;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   saw40    = 1'b0;

  i_fetch_queue_if #(.ADDR_W(AW1), .CNT_W(CW)) bus1 ();
  i_fetch_queue_if #(.ADDR_W(AW2), .CNT_W(CW)) bus2 ();

  i_fetch_queue #(.ADDR_W(AW1), .RESET_PC(RPC1), .DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(bus1)
  );
  i_fetch_queue #(.ADDR_W(AW2), .RESET_PC(RPC2), .DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  always #5 clk = ~clk;

  // Instruction memories: rdata = {addr[15:0], 16'hA5A5} one cycle after imem_en
  always @(posedge clk) if (bus1.imem_en) bus1.imem_rdata <= {bus1.imem_addr[15:0], 16'hA5A5};
  always @(posedge clk) if (bus2.imem_en) bus2.imem_rdata <= {8'h00, bus2.imem_addr, 16'hA5A5};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural model of instance 1: expected stream of PCs held in a queue
  logic [31:0] m_fetch = RPC1;
  logic [31:0] m_resp  = '0;
  bit          m_inflight = 1'b0;
  bit          m_align    = 1'b0;
  logic [31:0] m_q[$];

  always @(negedge clk) begin : compare
    bit en_exp;
    if (rst1) begin
      chk("rst_imem_en", bus1.imem_en, 0);
      chk("rst_out_valid", bus1.out_valid, 0);
      chk("rst_count", bus1.count, 0);
      chk("rst_align_err", bus1.align_err, 0);
      chk("rst_out_pc", bus1.out_pc, 0);
      chk("rst_out_instr", bus1.out_instr, 0);
      chk("rst_out_pc4", bus1.out_pc_plus_4, 0);
      m_fetch = RPC1; m_q.delete(); m_inflight = 1'b0; m_align = 1'b0;
    end else begin
      en_exp = !bus1.redirect_valid && ((m_q.size() + int'(m_inflight)) < int'(DEPTH));
      if (bus1.imem_en && bus1.imem_addr == 32'h40) saw40 = 1'b1;
      chk("imem_en", bus1.imem_en, en_exp);
      if (en_exp) chk("imem_addr", bus1.imem_addr, m_fetch);
      chk("count", bus1.count, m_q.size());
      chk("out_valid", bus1.out_valid, m_q.size() != 0);
      chk("align_err", bus1.align_err, m_align);
      if (m_q.size() != 0) begin
        chk("out_pc", bus1.out_pc, m_q[0]);
        chk("out_pc_plus_4", bus1.out_pc_plus_4, m_q[0] + 32'd4);
        chk("out_instr", bus1.out_instr, {m_q[0][15:0], 16'hA5A5});
      end
      if (bus1.redirect_valid) begin
        m_q.delete();
        m_inflight = 1'b0;
        m_fetch = {bus1.redirect_pc[31:2], 2'b00};
        m_align = (bus1.redirect_pc[1:0] != 2'b00);
      end else begin
        if (m_q.size() != 0 && bus1.out_ready) void'(m_q.pop_front());
        if (m_inflight) m_q.push_back(m_resp);
        m_inflight = en_exp;
        if (en_exp) begin
          m_resp  = m_fetch;
          m_fetch = m_fetch + 32'd4;
        end
        m_align = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0; bus1.out_ready = 1'b1;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0; bus2.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // 1: streaming from RESET_PC with out_ready=1
    @(posedge clk); #1 rst1 = 1'b0;
    @(negedge clk);
    chk("t1_first_issue_en", bus1.imem_en, 1);
    chk("t1_first_issue_addr", bus1.imem_addr, 32'h100);
    @(negedge clk);
    chk("t1_valid_after_1", bus1.out_valid, 0);
    @(negedge clk);
    chk("t1_valid_after_2", bus1.out_valid, 1);
    chk("t1_pc0", bus1.out_pc, 32'h100);
    chk("t1_pc0_plus4", bus1.out_pc_plus_4, 32'h104);
    chk("t1_instr0", bus1.out_instr, 32'h0100A5A5);
    @(negedge clk); chk("t1_pc1", bus1.out_pc, 32'h104);
    @(negedge clk); chk("t1_pc2", bus1.out_pc, 32'h108);

    // 2: stall with out_ready=0, then release
    @(posedge clk); #1 rst1 = 1'b1; bus1.out_ready = 1'b0;
    #1 chk("t2_async_rst_valid", bus1.out_valid, 0);
    chk("t2_async_rst_count", bus1.count, 0);
    @(posedge clk); #1 rst1 = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_full_count", bus1.count, 4);
    chk("t2_full_no_issue", bus1.imem_en, 0);
    chk("t2_full_head", bus1.out_pc, 32'h100);
    @(posedge clk); #1 bus1.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_drain_valid", bus1.out_valid, 1);
      chk("t2_drain_pc", bus1.out_pc, 32'h100 + 32'(4 * i));
    end

    // 3: redirect while full
    @(posedge clk); #1 bus1.out_ready = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 bus1.redirect_valid = 1'b1; bus1.redirect_pc = 32'h2000;
    @(negedge clk);
    chk("t3_T_count_full", bus1.count, 4);
    chk("t3_T_no_issue", bus1.imem_en, 0);
    @(posedge clk); #1 bus1.redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_T1_count", bus1.count, 0);
    chk("t3_T1_valid", bus1.out_valid, 0);
    chk("t3_T1_addr", bus1.imem_addr, 32'h2000);
    @(negedge clk); chk("t3_T2_valid", bus1.out_valid, 0);
    @(negedge clk);
    chk("t3_T3_valid", bus1.out_valid, 1);
    chk("t3_T3_pc", bus1.out_pc, 32'h2000);
    @(posedge clk); #1 bus1.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // 4: back-to-back redirects, last one wins
    saw40 = 1'b0;
    @(posedge clk); #1 bus1.redirect_valid = 1'b1; bus1.redirect_pc = 32'h40;
    @(negedge clk); chk("t4_T_no_issue", bus1.imem_en, 0);
    @(posedge clk); #1 bus1.redirect_pc = 32'h80;
    @(negedge clk); chk("t4_T1_no_issue", bus1.imem_en, 0);
    @(posedge clk); #1 bus1.redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_T2_en", bus1.imem_en, 1);
    chk("t4_T2_addr", bus1.imem_addr, 32'h80);
    @(negedge clk); chk("t4_T3_valid", bus1.out_valid, 0);
    @(negedge clk);
    chk("t4_T4_valid", bus1.out_valid, 1);
    chk("t4_T4_pc", bus1.out_pc, 32'h80);
    chk("t4_0x40_never_issued", saw40, 0);

    // 5: misaligned redirect target
    @(posedge clk); #1 bus1.redirect_valid = 1'b1; bus1.redirect_pc = 32'h203;
    @(negedge clk); chk("t5_T_align", bus1.align_err, 0);
    @(posedge clk); #1 bus1.redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_T1_align", bus1.align_err, 1);
    chk("t5_T1_addr", bus1.imem_addr, 32'h200);
    @(negedge clk); chk("t5_T2_align", bus1.align_err, 0);
    @(negedge clk);
    chk("t5_T3_valid", bus1.out_valid, 1);
    chk("t5_T3_pc", bus1.out_pc, 32'h200);
    chk("t5_T3_instr", bus1.out_instr, 32'h0200A5A5);

    // 6: 8-bit PC wrap and async reset mid-stream
    @(posedge clk); #1 rst2 = 1'b0;
    @(negedge clk); chk("t6_first_addr", bus2.imem_addr, 8'hF8);
    @(negedge clk);
    @(negedge clk);
    chk("t6_pc_F8", bus2.out_pc, 8'hF8);
    chk("t6_pc4_F8", bus2.out_pc_plus_4, 8'hFC);
    chk("t6_instr_F8", bus2.out_instr, 32'h00F8A5A5);
    @(negedge clk);
    chk("t6_pc_FC", bus2.out_pc, 8'hFC);
    chk("t6_pc4_FC_wrap", bus2.out_pc_plus_4, 8'h00);
    @(negedge clk);
    chk("t6_pc_00", bus2.out_pc, 8'h00);
    chk("t6_instr_00", bus2.out_instr, 32'h0000A5A5);
    @(negedge clk); chk("t6_pc_04", bus2.out_pc, 8'h04);
    @(posedge clk); #1 rst2 = 1'b1;
    #1 chk("t6_rst_valid", bus2.out_valid, 0);
    chk("t6_rst_en", bus2.imem_en, 0);
    chk("t6_rst_count", bus2.count, 0);
    @(posedge clk); #1 rst2 = 1'b0;
    @(negedge clk); chk("t6_restart_addr", bus2.imem_addr, 8'hF8);
    @(negedge clk);
    @(negedge clk);
    chk("t6_restart_valid", bus2.out_valid, 1);
    chk("t6_restart_pc", bus2.out_pc, 8'hF8);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
